// File: rtl/mandel_pkg.sv
// Shared types and default geometry for the Mandelbrot coordinate generator.
// Coordinates are signed 4.23 fixed point.
package mandel_pkg;

  localparam int COORD_W   = 27;
  localparam int FRAC_BITS = 23;
  localparam int H_PIXELS  = 640;
  localparam int V_PIXELS  = 480;
  localparam int CYC_W     = 32;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mandel_param_shadow.sv
// Shadow copies of the view parameters for the frame in flight, plus the
// re-render trigger raised when the live parameters drift or start pulses.
module mandel_param_shadow
  import mandel_pkg::*;
#(
  parameter int W = COORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] xstart_i,
  input  logic [W-1:0] ystart_i,
  input  logic [W-1:0] xstep_i,
  input  logic [W-1:0] ystep_i,
  input  logic         start_i,
  input  logic         load_i,
  output logic [W-1:0] xstart_sh_o,
  output logic [W-1:0] ystart_sh_o,
  output logic [W-1:0] xstep_sh_o,
  output logic [W-1:0] ystep_sh_o,
  output logic         trigger_o
);

  logic [W-1:0] xstart_q;
  logic [W-1:0] ystart_q;
  logic [W-1:0] xstep_q;
  logic [W-1:0] ystep_q;
  logic         chg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xstart_q <= '0;
      ystart_q <= '0;
      xstep_q  <= '0;
      ystep_q  <= '0;
    end else if (load_i) begin
      xstart_q <= xstart_i;
      ystart_q <= ystart_i;
      xstep_q  <= xstep_i;
      ystep_q  <= ystep_i;
    end
  end

  assign chg = (xstart_i != xstart_q) || (ystart_i != ystart_q) ||
               (xstep_i  != xstep_q)  || (ystep_i  != ystep_q);

  assign trigger_o   = chg | start_i;
  assign xstart_sh_o = xstart_q;
  assign ystart_sh_o = ystart_q;
  assign xstep_sh_o  = xstep_q;
  assign ystep_sh_o  = ystep_q;

endmodule

// File: rtl/mandel_coord_gen.sv
// Raster-order pixel coordinate generator: emits (c_re, c_im, x, y) beats on a
// valid/ready stream and reports frame completion and render cycle count.
module mandel_coord_gen
  import mandel_pkg::*;
#(
  parameter int H_PIXELS = mandel_pkg::H_PIXELS,
  parameter int V_PIXELS = mandel_pkg::V_PIXELS,
  parameter int COORD_W  = mandel_pkg::COORD_W,
  parameter int CYC_W    = mandel_pkg::CYC_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] xstart,
  input  logic [COORD_W-1:0] ystart,
  input  logic [COORD_W-1:0] xstep,
  input  logic [COORD_W-1:0] ystep,
  input  logic               start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] c_re,
  output logic [COORD_W-1:0] c_im,
  output logic [9:0]         pix_x,
  output logic [8:0]         pix_y,
  output logic               out_last,
  output logic               frame_done,
  output logic [CYC_W-1:0]   frame_cycles
);

  localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
  localparam logic [8:0] Y_LAST = 9'(V_PIXELS - 1);

  state_e             state_q;
  logic               out_valid_q;
  logic [COORD_W-1:0] c_re_q;
  logic [COORD_W-1:0] c_im_q;
  logic [9:0]         pix_x_q;
  logic [8:0]         pix_y_q;
  logic               frame_done_q;
  logic [CYC_W-1:0]   frame_cycles_q;
  logic [CYC_W-1:0]   cnt_q;
  logic               restart_pend_q;

  logic [COORD_W-1:0] xstart_sh;
  logic [COORD_W-1:0] ystart_sh;
  logic [COORD_W-1:0] xstep_sh;
  logic [COORD_W-1:0] ystep_sh;
  logic               trigger;
  logic               last_beat;
  logic               restart;
  logic [CYC_W-1:0]   cnt_d;

  mandel_param_shadow #(
    .W(COORD_W)
  ) u_shadow (
    .clk         (clk),
    .rst_n       (reset_n),
    .xstart_i    (xstart),
    .ystart_i    (ystart),
    .xstep_i     (xstep),
    .ystep_i     (ystep),
    .start_i     (start),
    .load_i      (state_q == LOAD),
    .xstart_sh_o (xstart_sh),
    .ystart_sh_o (ystart_sh),
    .xstep_sh_o  (xstep_sh),
    .ystep_sh_o  (ystep_sh),
    .trigger_o   (trigger)
  );

  assign last_beat = (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    restart = restart_pend_q | trigger;
    if (!(&cnt_q)) cnt_d = cnt_q + CYC_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      out_valid_q    <= 1'b0;
      c_re_q         <= '0;
      c_im_q         <= '0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      frame_done_q   <= 1'b0;
      frame_cycles_q <= '0;
      cnt_q          <= '0;
      restart_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (trigger) state_q <= LOAD;

        LOAD: begin
          c_re_q         <= xstart;
          c_im_q         <= ystart;
          pix_x_q        <= '0;
          pix_y_q        <= '0;
          frame_done_q   <= 1'b0;
          cnt_q          <= CYC_W'(1);
          restart_pend_q <= 1'b0;
          out_valid_q    <= 1'b1;
          state_q        <= RUN;
        end

        RUN: begin
          cnt_q <= cnt_d;
          if (trigger) restart_pend_q <= 1'b1;
          if (!out_valid_q) begin
            if (restart) state_q <= LOAD;
          end else if (out_ready) begin
            // A pending restart takes precedence over finishing the frame.
            if (restart) begin
              out_valid_q <= 1'b0;
              state_q     <= LOAD;
            end else if (last_beat) begin
              out_valid_q    <= 1'b0;
              frame_cycles_q <= cnt_d;
              frame_done_q   <= 1'b1;
              state_q        <= DONE;
            end else if (pix_x_q != X_LAST) begin
              pix_x_q <= pix_x_q + 10'd1;
              c_re_q  <= c_re_q + xstep_sh;
            end else begin
              pix_x_q <= '0;
              c_re_q  <= xstart_sh;
              pix_y_q <= pix_y_q + 9'd1;
              c_im_q  <= c_im_q - ystep_sh;
            end
          end
        end

        DONE: if (trigger) state_q <= LOAD;

        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign c_re         = c_re_q;
  assign c_im         = c_im_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign out_last     = last_beat;
  assign frame_done   = frame_done_q;
  assign frame_cycles = frame_cycles_q;

endmodule

// File: tb/tb_mandel_coord_gen.sv
// Directed scoreboard bench for mandel_coord_gen on a 4x2 screen.
module tb_mandel_coord_gen;

  localparam int HP = 4;
  localparam int VP = 2;
  localparam int CW = 27;

  typedef struct {
    logic [CW-1:0] re;
    logic [CW-1:0] im;
    logic [9:0]    x;
    logic [8:0]    y;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] xstart, ystart, xstep, ystep;
  logic          start;
  logic          out_valid, out_ready;
  logic [CW-1:0] c_re, c_im;
  logic [9:0]    pix_x;
  logic [8:0]    pix_y;
  logic          out_last, frame_done;
  logic [31:0]   frame_cycles;

  beat_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  mandel_coord_gen #(
    .H_PIXELS(HP),
    .V_PIXELS(VP),
    .COORD_W (CW),
    .CYC_W   (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .xstart       (xstart),
    .ystart       (ystart),
    .xstep        (xstep),
    .ystep        (ystep),
    .start        (start),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .c_re         (c_re),
    .c_im         (c_im),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .out_last     (out_last),
    .frame_done   (frame_done),
    .frame_cycles (frame_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected beats: c_re = xs + x*xst, c_im = ys - y*yst, modulo 2^CW.
  task automatic push_frame(input logic [CW-1:0] xs, input logic [CW-1:0] ys,
                            input logic [CW-1:0] xst, input logic [CW-1:0] yst,
                            input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.x    = 10'(i % HP);
      b.y    = 9'(i / HP);
      b.re   = xs + CW'(i % HP) * xst;
      b.im   = ys - CW'(i / HP) * yst;
      b.last = (i == HP * VP - 1);
      sb.push_back(b);
    end
  endtask

  // Consume n beats, comparing against the scoreboard; optional backpressure
  // and an xstep change applied when beat index change_at is presented.
  task automatic run_beats(input int n, input bit bp, input int change_at,
                           input logic [CW-1:0] new_xstep,
                           output int first_valid, output int vcycles,
                           output int done_bad);
    int            got = 0;
    int            cyc = 0;
    bit            stalled = 0;
    bit            changed = 0;
    int            ofs = $urandom_range(0, 3);
    bit            pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [CW-1:0] s_re, s_im;
    logic [18:0]   s_xy;
    first_valid = -1;
    vcycles     = 0;
    done_bad    = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      out_ready = bp ? pat[(cyc + ofs) % 4] : 1'b1;
      if (!changed && got == change_at) begin
        xstep   = new_xstep;
        changed = 1;
      end
      if (out_valid) begin
        vcycles++;
        if (first_valid < 0) first_valid = cyc;
        if (frame_done) done_bad++;
        if (stalled) begin
          check("stall_coord", {s_re, s_im}, {c_re, c_im});
          check("stall_pix", 64'(s_xy), 64'({pix_x, pix_y}));
        end
        if (out_ready) begin
          beat_t e;
          e = sb.pop_front();
          check("c_re", 64'(c_re), 64'(e.re));
          check("c_im", 64'(c_im), 64'(e.im));
          check("pix_xy", 64'({pix_x, pix_y}), 64'({e.x, e.y}));
          check("out_last", 64'(out_last), 64'(e.last));
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          s_re    = c_re;
          s_im    = c_im;
          s_xy    = {pix_x, pix_y};
        end
      end else begin
        stalled = 0;
      end
    end
    if (got < n) check("beat_timeout", 64'(got), 64'(n));
    out_ready = 1'b1;
  endtask

  task automatic check_done(input logic [31:0] exp_cycles);
    @(negedge clk);
    check("frame_done", 64'(frame_done), 64'd1);
    check("valid_after_last", 64'(out_valid), 64'd0);
    check("frame_cycles", 64'(frame_cycles), 64'(exp_cycles));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({out_valid, out_last, frame_done, pix_x, pix_y}), 64'd0);
    check(tag, 64'({c_re, c_im}), 64'd0);
    check(tag, 64'(frame_cycles), 64'd0);
  endtask

  initial begin
    int fv, vc, db;
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    xstart    = 27'h7000000;
    ystart    = 27'h0800000;
    xstep     = 27'h000999A;
    ystep     = 27'h0008889;

    // Reset state, then the nonzero inputs differ from zeroed shadows.
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset_n = 1'b1;
    push_frame(xstart, ystart, xstep, ystep, 8);
    run_beats(8, 0, -1, '0, fv, vc, db);
    check("latency_chg", 64'(fv), 64'd2);
    check("done_during_run", 64'(db), 64'd0);
    check_done(32'd9);

    // Start pulse re-renders with identical parameters.
    @(negedge clk);
    start = 1'b1;
    push_frame(xstart, ystart, xstep, ystep, 8);
    run_beats(8, 0, -1, '0, fv, vc, db);
    check("latency_start", 64'(fv), 64'd2);
    check_done(32'd9);

    // Backpressure: frame_cycles counts every RUN cycle, stalled or not.
    @(negedge clk);
    start = 1'b1;
    push_frame(xstart, ystart, xstep, ystep, 8);
    run_beats(8, 1, -1, '0, fv, vc, db);
    check("bp_done_during_run", 64'(db), 64'd0);
    check_done(32'(1 + vc));

    // xstep changes while beat 4 is presented: beat 4 completes, then restart.
    @(negedge clk);
    start = 1'b1;
    push_frame(xstart, ystart, xstep, ystep, 4);
    push_frame(xstart, ystart, 27'h0001000, ystep, 8);
    run_beats(4, 0, 3, 27'h0001000, fv, vc, db);
    check("abort_done", 64'(db), 64'd0);
    run_beats(8, 0, -1, '0, fv, vc, db);
    check("restart_latency", 64'(fv), 64'd2);
    check("restart_done_during_run", 64'(db), 64'd0);
    check_done(32'd9);

    // Wrap: 0x3FFFFFF + 1 rolls over to 0x4000000 silently.
    @(negedge clk);
    xstart = 27'h3FFFFFF;
    xstep  = 27'h0000001;
    push_frame(xstart, ystart, xstep, ystep, 8);
    run_beats(8, 0, -1, '0, fv, vc, db);
    check_done(32'd9);

    // Asynchronous reset while pixel 2/0 is on the bus.
    @(negedge clk);
    start = 1'b1;
    push_frame(xstart, ystart, xstep, ystep, 2);
    run_beats(2, 0, -1, '0, fv, vc, db);
    @(negedge clk);
    check("pre_reset_pix", 64'({out_valid, pix_x, pix_y}), 64'({1'b1, 10'd2, 9'd0}));
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    xstart = '0;
    ystart = '0;
    xstep  = '0;
    ystep  = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_hold", 64'({out_valid, frame_done}), 64'd0);
    end
    start = 1'b1;
    push_frame(xstart, ystart, xstep, ystep, 8);
    run_beats(8, 0, -1, '0, fv, vc, db);
    check("post_reset_latency", 64'(fv), 64'd2);
    check_done(32'd9);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
